ras_predecode: RTL and testbench

Predecode stage between the instruction-fetch return path and the decode queue. It scans each fetched 4-instruction bundle for the first call (BL) or return (JIRL r0,r1,0) and emits speculative push/pop updates to the return-address stack when the BTB missed the call or return. It consumes the stack's registered top-of-stack prediction and redirects fetch when predecode disagrees with the BTB. After a redirect it squashes the in-flight shadow bundles.

---
 rtl/ras_predecode_pkg.sv | 42 ++++
 rtl/ras_predecode_slot.sv | 34 +++
 rtl/ras_predecode.sv | 228 ++++++++++++++++++++++
 tb/tb_ras_predecode.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_predecode_pkg.sv
// Shared definitions for the return-address-stack predecode stage:
// BTB type codes, stack pointer update encodings, opcode constants and
// the predecode FSM state type.
package ras_predecode_pkg;

  // Instructions per fetch bundle (16-byte aligned bundle)
  localparam int FETCH_WIDTH = 4;

  // Instruction address bus width and type
  localparam int INST_ADDR_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  // BTB predicted branch type for a bundle
  localparam logic [2:0] TYPE_NONE  = 3'd0;
  localparam logic [2:0] TYPE_CALL  = 3'd1;
  localparam logic [2:0] TYPE_RTURN = 3'd2;

  // Speculative stack update encodings
  localparam logic [1:0] PTR_NONE = 2'b00;
  localparam logic [1:0] PTR_PUSH = 2'b10;
  localparam logic [1:0] PTR_POP  = 2'b01;

  // Major opcodes (inst[31:26])
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_JIRL = 6'b010011;

  // JIRL r0, r1, 0 operand fields
  localparam logic [4:0] RET_RD = 5'd0;
  localparam logic [4:0] RET_RJ = 5'd1;

  // Predecode FSM: RUN passes bundles, SHADOW drops in-flight bundles
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } pd_state_e;

  // First address of the bundle that follows the one containing pc
  function automatic inst_addr_t seq_next_bundle(input inst_addr_t pc);
    return {pc[31:4] + 28'd1, 4'b0000};
  endfunction

endpackage

// File: rtl/ras_predecode_slot.sv
// Per-slot combinational decoder: classifies one instruction as a call
// (BL) or a return (JIRL r0,r1,0) and computes the call target and the
// link address for a push.
module ras_slot_decode
  import ras_predecode_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_is_call,
  output logic        o_is_return,
  output logic [31:0] o_target,
  output logic [31:0] o_link
);

  logic [5:0]  w_opcode;
  logic [31:0] w_offset;

  assign w_opcode = i_inst[31:26];

  // BL offset is split: offs[25:16] in inst[9:0], offs[15:0] in inst[25:10]
  assign w_offset = {{4{i_inst[9]}}, i_inst[9:0], i_inst[25:10], 2'b00};

  // Classify the instruction and form the call target / return link
  always_comb begin
    o_is_call   = (w_opcode == OP_BL);
    o_is_return = (w_opcode == OP_JIRL) &&
                  (i_inst[4:0] == RET_RD) &&
                  (i_inst[9:5] == RET_RJ) &&
                  (i_inst[25:10] == 16'd0);
    o_target    = i_pc + w_offset;
    o_link      = i_pc + 32'd4;
  end

endmodule

// File: rtl/ras_predecode.sv
// Predecode stage between fetch return and decode. Finds the first call or
// return in each bundle, issues speculative RAS push/pop when the BTB missed
// it, redirects fetch when predecode and BTB disagree, and squashes the
// shadow bundles that were already in flight when the redirect went out.
//
// Handshake: a bundle moves from fetch into the output register when
// i_fetch_able && o_fetch_ready; o_fetch_ready = i_out_ready || !o_out_able,
// so the output register is either empty or being drained by decode.
// While o_out_able && !i_out_ready all o_out_* hold and nothing is accepted.
module ras_predecode
  import ras_predecode_pkg::*;
#(
  parameter int SHADOW_CYCLES = 2
) (
  input  logic         i_clk,
  input  logic         i_rest,
  input  logic         i_pre_flash,
  input  logic         i_fetch_able,
  input  logic [31:0]  i_fetch_pc,
  input  logic [127:0] i_fetch_inst,
  input  logic [2:0]   i_fetch_btb_type,
  input  logic [1:0]   i_fetch_btb_slot,
  output logic         o_fetch_ready,
  input  logic         i_ras_able,
  input  logic [31:0]  i_ras_addr,
  output logic         o_up_able,
  output logic [1:0]   o_up_ptr_type,
  output logic [31:0]  o_up_addr_date,
  output logic         o_pre_redirect,
  output logic [31:0]  o_pre_redirect_pc,
  output logic         o_out_able,
  output logic [31:0]  o_out_pc,
  output logic [127:0] o_out_inst,
  output logic [3:0]   o_out_mask,
  input  logic         i_out_ready,
  output logic         o_dbg_state,
  output logic [2:0]   o_dbg_shadow_cnt
);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  pd_state_e    r_state;
  logic [2:0]   r_shadow_cnt;
  logic         r_out_able;
  logic [31:0]  r_out_pc;
  logic [127:0] r_out_inst;
  logic [3:0]   r_out_mask;
  logic         r_up_able;
  logic [1:0]   r_up_ptr_type;
  logic [31:0]  r_up_addr_date;
  logic         r_pre_redirect;
  logic [31:0]  r_pre_redirect_pc;

  // ---------------------------------------------------------------------
  // Per-slot decode
  // ---------------------------------------------------------------------
  logic [FETCH_WIDTH-1:0] w_slot_valid;
  logic [FETCH_WIDTH-1:0] w_is_call;
  logic [FETCH_WIDTH-1:0] w_is_return;
  logic [31:0]            w_target [FETCH_WIDTH];
  logic [31:0]            w_link   [FETCH_WIDTH];

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
    localparam logic [1:0] SLOT_ID = 2'(g);
    logic [31:0] w_slot_pc;

    assign w_slot_pc       = {i_fetch_pc[31:4], SLOT_ID, 2'b00};
    // Slots before the entry point of the bundle carry no valid work
    assign w_slot_valid[g] = (SLOT_ID >= i_fetch_pc[3:2]);

    ras_slot_decode u_slot_decode (
      .i_pc        (w_slot_pc),
      .i_inst      (i_fetch_inst[32*g +: 32]),
      .o_is_call   (w_is_call[g]),
      .o_is_return (w_is_return[g]),
      .o_target    (w_target[g]),
      .o_link      (w_link[g])
    );
  end

  // ---------------------------------------------------------------------
  // Priority pick and redirect decision
  // ---------------------------------------------------------------------
  logic        w_hit;
  logic [1:0]  w_hit_k;
  logic [3:0]  w_mask;
  logic        w_call_k;
  logic        w_ret_k;
  logic        w_btb_slot_k;
  logic        w_btb_is_branch;
  logic        w_push;
  logic        w_pop;
  logic        w_false_btb;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_fire;
  logic        w_accept;

  // Lowest valid call/return slot wins (scan from the top so the lowest
  // slot is the last one written)
  always_comb begin
    w_hit   = 1'b0;
    w_hit_k = 2'd0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (w_slot_valid[i] && (w_is_call[i] || w_is_return[i])) begin
        w_hit   = 1'b1;
        w_hit_k = 2'(i);
      end
    end
  end

  // Decode sees valid slots up to and including the winning slot
  always_comb begin
    w_mask = 4'b0000;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_mask[i] = w_slot_valid[i] && (!w_hit || (i <= int'(w_hit_k)));
    end
  end

  // Compare predecode against the BTB and choose update / redirect
  always_comb begin
    w_call_k        = w_hit && w_is_call[w_hit_k];
    w_ret_k         = w_hit && w_is_return[w_hit_k] && !w_is_call[w_hit_k];
    w_btb_slot_k    = (i_fetch_btb_slot == w_hit_k);
    w_btb_is_branch = (i_fetch_btb_type == TYPE_CALL) ||
                      (i_fetch_btb_type == TYPE_RTURN);

    w_push      = w_call_k &&
                  !((i_fetch_btb_type == TYPE_CALL) && w_btb_slot_k);
    w_pop       = w_ret_k &&
                  !((i_fetch_btb_type == TYPE_RTURN) && w_btb_slot_k);
    // BTB claimed a call/return the bundle does not contain
    w_false_btb = !w_hit && w_btb_is_branch;

    w_redirect    = w_push || (w_pop && i_ras_able) || w_false_btb;
    w_redirect_pc = 32'd0;
    if (w_push) begin
      w_redirect_pc = w_target[w_hit_k];
    end else if (w_pop && i_ras_able) begin
      w_redirect_pc = i_ras_addr;
    end else if (w_false_btb) begin
      w_redirect_pc = seq_next_bundle(i_fetch_pc);
    end
  end

  assign o_fetch_ready = i_out_ready || !r_out_able;
  assign w_fire        = i_fetch_able && o_fetch_ready;
  // Flush wins over a bundle arriving in the same cycle
  assign w_accept      = w_fire && (r_state == ST_RUN) && !i_pre_flash;

  // ---------------------------------------------------------------------
  // Shadow FSM: after a redirect drop SHADOW_CYCLES arriving bundles
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rest || i_pre_flash) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && w_redirect) begin
            r_state      <= ST_SHADOW;
            r_shadow_cnt <= 3'(SHADOW_CYCLES);
          end
        end
        ST_SHADOW: begin
          if (w_fire) begin
            r_shadow_cnt <= r_shadow_cnt - 3'd1;
            if (r_shadow_cnt <= 3'd1) begin
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_shadow_cnt <= 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output bundle register and single-cycle update/redirect pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rest || i_pre_flash) begin
      r_out_able        <= 1'b0;
      r_out_pc          <= 32'd0;
      r_out_inst        <= 128'd0;
      r_out_mask        <= 4'd0;
      r_up_able         <= 1'b0;
      r_up_ptr_type     <= PTR_NONE;
      r_up_addr_date    <= 32'd0;
      r_pre_redirect    <= 1'b0;
      r_pre_redirect_pc <= 32'd0;
    end else begin
      r_up_able      <= 1'b0;
      r_pre_redirect <= 1'b0;
      if (w_accept) begin
        r_out_able        <= 1'b1;
        r_out_pc          <= i_fetch_pc;
        r_out_inst        <= i_fetch_inst;
        r_out_mask        <= w_mask;
        r_up_able         <= w_push || w_pop;
        r_up_ptr_type     <= w_push ? PTR_PUSH : (w_pop ? PTR_POP : PTR_NONE);
        r_up_addr_date    <= w_push ? w_link[w_hit_k] : 32'd0;
        r_pre_redirect    <= w_redirect;
        r_pre_redirect_pc <= w_redirect_pc;
      end else if (i_out_ready) begin
        r_out_able <= 1'b0;
      end
    end
  end

  assign o_out_able        = r_out_able;
  assign o_out_pc          = r_out_pc;
  assign o_out_inst        = r_out_inst;
  assign o_out_mask        = r_out_mask;
  assign o_up_able         = r_up_able;
  assign o_up_ptr_type     = r_up_ptr_type;
  assign o_up_addr_date    = r_up_addr_date;
  assign o_pre_redirect    = r_pre_redirect;
  assign o_pre_redirect_pc = r_pre_redirect_pc;
  assign o_dbg_state       = r_state;
  assign o_dbg_shadow_cnt  = r_shadow_cnt;

endmodule

// File: tb/tb_ras_predecode.sv
// Bench for ras_predecode: directed vector table, randomized bundles against
// a behavioural model, and hand sequences for shadow, flush, reset and
// backpressure behaviour.
module tb_ras_predecode;
  import ras_predecode_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rest;
  logic         pre_flash;
  logic         fetch_able;
  logic [31:0]  fetch_pc;
  logic [127:0] fetch_inst;
  logic [2:0]   btb_type;
  logic [1:0]   btb_slot;
  logic         fetch_ready;
  logic         ras_able;
  logic [31:0]  ras_addr;
  logic         up_able;
  logic [1:0]   up_ptr_type;
  logic [31:0]  up_addr_date;
  logic         pre_redirect;
  logic [31:0]  pre_redirect_pc;
  logic         out_able;
  logic [31:0]  out_pc;
  logic [127:0] out_inst;
  logic [3:0]   out_mask;
  logic         out_ready;
  logic         dbg_state;
  logic [2:0]   dbg_shadow_cnt;

  ras_predecode #(.SHADOW_CYCLES(2)) dut (
    .i_clk             (clk),
    .i_rest            (rest),
    .i_pre_flash       (pre_flash),
    .i_fetch_able      (fetch_able),
    .i_fetch_pc        (fetch_pc),
    .i_fetch_inst      (fetch_inst),
    .i_fetch_btb_type  (btb_type),
    .i_fetch_btb_slot  (btb_slot),
    .o_fetch_ready     (fetch_ready),
    .i_ras_able        (ras_able),
    .i_ras_addr        (ras_addr),
    .o_up_able         (up_able),
    .o_up_ptr_type     (up_ptr_type),
    .o_up_addr_date    (up_addr_date),
    .o_pre_redirect    (pre_redirect),
    .o_pre_redirect_pc (pre_redirect_pc),
    .o_out_able        (out_able),
    .o_out_pc          (out_pc),
    .o_out_inst        (out_inst),
    .o_out_mask        (out_mask),
    .i_out_ready       (out_ready),
    .o_dbg_state       (dbg_state),
    .o_dbg_shadow_cnt  (dbg_shadow_cnt)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP   = 32'h0340_0000;
  localparam logic [31:0] RET   = 32'h4C00_0020;
  localparam logic [31:0] RETR2 = 32'h4C00_0040;
  localparam logic [31:0] BL40  = 32'h5400_4000;
  localparam logic [31:0] BLM   = 32'h57FF_03FF;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] insts;
    logic [2:0]   bt;
    logic [1:0]   bs;
    logic         ra;
    logic [31:0]  raddr;
    logic [3:0]   mask;
    logic         up;
    logic [1:0]   typ;
    logic [31:0]  uaddr;
    logic         redir;
    logic [31:0]  rpc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [127:0] insts,
                              input logic [2:0] bt, input logic [1:0] bs,
                              input logic ra, input logic [31:0] raddr,
                              input logic [3:0] mask, input logic up,
                              input logic [1:0] typ, input logic [31:0] uaddr,
                              input logic redir, input logic [31:0] rpc);
    vec_t v;
    v.pc = pc; v.insts = insts; v.bt = bt; v.bs = bs; v.ra = ra; v.raddr = raddr;
    v.mask = mask; v.up = up; v.typ = typ; v.uaddr = uaddr; v.redir = redir; v.rpc = rpc;
    return v;
  endfunction

  // Reference model: straight from the predecode rules, per bundle
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int first;
    bit first_call;
    int start;
    int off;
    logic [31:0] w;
    logic [31:0] base;
    logic [31:0] spc;
    r = v;
    r.mask = 4'd0; r.up = 1'b0; r.typ = 2'b00; r.uaddr = 32'd0; r.redir = 1'b0; r.rpc = 32'd0;
    first = -1;
    first_call = 1'b0;
    start = int'((v.pc >> 2) & 32'd3);
    base = v.pc & 32'hFFFF_FFF0;
    for (int s = start; s < 4; s++) begin
      w = v.insts[32*s +: 32];
      if (first < 0 && (((w >> 26) == 32'd21) || (w == RET))) begin
        first = s;
        first_call = ((w >> 26) == 32'd21);
      end
    end
    for (int s = 0; s < 4; s++) r.mask[s] = (s >= start) && (first < 0 || s <= first);
    if (first >= 0) begin
      spc = base + 32'(4 * first);
      w = v.insts[32*first +: 32];
      if (first_call) begin
        off = int'(((w & 32'h3FF) << 16) | ((w >> 10) & 32'hFFFF));
        if (off >= (1 << 25)) off = off - (1 << 26);
        if (!(v.bt == TYPE_CALL && int'(v.bs) == first)) begin
          r.up = 1'b1; r.typ = 2'b10; r.uaddr = spc + 32'd4;
          r.redir = 1'b1; r.rpc = spc + 32'(off * 4);
        end
      end else if (!(v.bt == TYPE_RTURN && int'(v.bs) == first)) begin
        r.up = 1'b1; r.typ = 2'b01; r.redir = v.ra; r.rpc = v.raddr;
      end
    end else if (v.bt == TYPE_CALL || v.bt == TYPE_RTURN) begin
      r.redir = 1'b1; r.rpc = base + 32'd16;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    fetch_able = 1'b0;
    pre_flash  = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    fetch_able = 1'b1;
    fetch_pc   = v.pc;
    fetch_inst = v.insts;
    btb_type   = v.bt;
    btb_slot   = v.bs;
    ras_able   = v.ra;
    ras_addr   = v.raddr;
  endtask

  task automatic do_flash();
    fetch_able = 1'b0;
    pre_flash  = 1'b1;
    step();
    pre_flash  = 1'b0;
  endtask

  // One isolated bundle: flush, present, check result and pulse drop
  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] epc;
    do_flash();
    drive(v);
    exp_q.push_back(v.pc);
    step();
    go_idle();
    epc = exp_q.pop_front();
    check({tag, "_out_able"}, out_able, 1'b1);
    check({tag, "_out_pc"}, out_pc, epc);
    check({tag, "_out_inst"}, out_inst, v.insts);
    check({tag, "_mask"}, out_mask, v.mask);
    check({tag, "_up_able"}, up_able, v.up);
    if (v.up) check({tag, "_up_type"}, up_ptr_type, v.typ);
    if (v.up && v.typ == 2'b10) check({tag, "_up_addr"}, up_addr_date, v.uaddr);
    check({tag, "_redirect"}, pre_redirect, v.redir);
    if (v.redir) check({tag, "_redirect_pc"}, pre_redirect_pc, v.rpc);
    step();
    check({tag, "_pulse_up"}, up_able, 1'b0);
    check({tag, "_pulse_redir"}, pre_redirect, 1'b0);
    check({tag, "_drained"}, out_able, 1'b0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t cv;
    vec_t nv;
    vec_t rv;
    int ups;
    logic [31:0] tmp;

    rest = 1'b0; pre_flash = 1'b0; fetch_able = 1'b0; fetch_pc = 32'd0;
    fetch_inst = 128'd0; btb_type = TYPE_NONE; btb_slot = 2'd0;
    ras_able = 1'b0; ras_addr = 32'd0; out_ready = 1'b1;

    vecs[0]  = mk(32'h1C00_0000, {NOP, NOP, BL40, NOP}, TYPE_NONE, 2'd0, 1'b0, 32'd0,
                  4'b0011, 1'b1, 2'b10, 32'h1C00_0008, 1'b1, 32'h1C00_0044);
    vecs[1]  = mk(32'h1C00_0000, {NOP, NOP, NOP, RET}, TYPE_NONE, 2'd0, 1'b1, 32'h1C00_0100,
                  4'b0001, 1'b1, 2'b01, 32'd0, 1'b1, 32'h1C00_0100);
    vecs[2]  = mk(32'h1C00_0000, {NOP, NOP, NOP, RET}, TYPE_NONE, 2'd0, 1'b0, 32'h1C00_0100,
                  4'b0001, 1'b1, 2'b01, 32'd0, 1'b0, 32'd0);
    vecs[3]  = mk(32'h1C00_0000, {NOP, BL40, NOP, NOP}, TYPE_CALL, 2'd2, 1'b0, 32'd0,
                  4'b0111, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    vecs[4]  = mk(32'h1C00_0010, {NOP, NOP, NOP, NOP}, TYPE_RTURN, 2'd3, 1'b0, 32'd0,
                  4'b1111, 1'b0, 2'b00, 32'd0, 1'b1, 32'h1C00_0020);
    vecs[5]  = mk(32'h1C00_0008, {RET, NOP, NOP, BL40}, TYPE_NONE, 2'd0, 1'b1, 32'h1C00_0200,
                  4'b1100, 1'b1, 2'b01, 32'd0, 1'b1, 32'h1C00_0200);
    vecs[6]  = mk(32'h1C00_000C, {BLM, NOP, NOP, NOP}, TYPE_CALL, 2'd2, 1'b0, 32'd0,
                  4'b1000, 1'b1, 2'b10, 32'h1C00_0010, 1'b1, 32'h1BFF_FF0C);
    vecs[7]  = mk(32'h1C00_0004, {NOP, NOP, NOP, NOP}, TYPE_NONE, 2'd0, 1'b0, 32'd0,
                  4'b1110, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    vecs[8]  = mk(32'h1C00_0000, {NOP, NOP, NOP, RET}, TYPE_CALL, 2'd0, 1'b1, 32'h1C00_0300,
                  4'b0001, 1'b1, 2'b01, 32'd0, 1'b1, 32'h1C00_0300);
    vecs[9]  = mk(32'h1C00_0000, {NOP, NOP, RET, NOP}, TYPE_RTURN, 2'd1, 1'b1, 32'h1C00_0300,
                  4'b0011, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
    vecs[10] = mk(32'h1C00_0000, {NOP, NOP, NOP, RETR2}, TYPE_NONE, 2'd0, 1'b1, 32'h1C00_0300,
                  4'b1111, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);

    // Reset holds everything cleared even with a bundle presented
    drive(vecs[0]);
    repeat (3) step();
    check("rst_out_able", out_able, 1'b0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 128'd0);
    check("rst_out_mask", out_mask, 4'd0);
    check("rst_up_able", up_able, 1'b0);
    check("rst_up_type", up_ptr_type, 2'd0);
    check("rst_up_addr", up_addr_date, 32'd0);
    check("rst_redirect", pre_redirect, 1'b0);
    check("rst_redirect_pc", pre_redirect_pc, 32'd0);
    check("rst_fetch_ready", fetch_ready, 1'b1);
    check("rst_state", dbg_state, 1'b0);
    go_idle();
    rest = 1'b1;
    step();

    // Directed table
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Randomized bundles against the model
    for (int n = 0; n < 60; n++) begin
      rv.pc = $urandom() & 32'hFFFF_FFFC;
      for (int s = 0; s < 4; s++) begin
        tmp = $urandom();
        case ($urandom_range(0, 5))
          0, 1: rv.insts[32*s +: 32] = {6'b010101, tmp[25:0]};
          2:    rv.insts[32*s +: 32] = RET;
          3:    rv.insts[32*s +: 32] = RETR2;
          default: rv.insts[32*s +: 32] = tmp;
        endcase
      end
      rv.bt = 3'($urandom_range(0, 3));
      rv.bs = 2'($urandom_range(0, 3));
      rv.ra = 1'($urandom_range(0, 1));
      rv.raddr = $urandom();
      run_vec($sformatf("rnd%0d", n), model(rv));
    end

    cv = vecs[0];
    nv = vecs[7];

    // Shadow: two back-to-back bundles after a redirect are dropped
    do_flash();
    drive(cv);
    step();
    check("shd_redir_out", out_able, 1'b1);
    check("shd_state", dbg_state, 1'b1);
    nv.pc = 32'h1C00_0100; drive(nv);
    step();
    check("shd_drop1_out", out_able, 1'b0);
    check("shd_drop1_up", up_able, 1'b0);
    check("shd_drop1_redir", pre_redirect, 1'b0);
    nv.pc = 32'h1C00_0110; drive(nv);
    step();
    check("shd_drop2_out", out_able, 1'b0);
    nv.pc = 32'h1C00_0120; drive(nv);
    step();
    go_idle();
    check("shd_pass_out", out_able, 1'b1);
    check("shd_pass_pc", out_pc, 32'h1C00_0120);

    // Shadow counter waits for bundles: idle cycles do not use it up
    do_flash();
    drive(cv);
    step();
    go_idle();
    repeat (2) step();
    nv.pc = 32'h1C00_0130; drive(nv);
    step();
    go_idle();
    check("shd_idle_drop", out_able, 1'b0);
    check("shd_idle_state", dbg_state, 1'b1);

    // Flush mid-shadow: the next bundle passes
    do_flash();
    drive(cv);
    step();
    nv.pc = 32'h1C00_0140; drive(nv); pre_flash = 1'b1;
    step();
    pre_flash = 1'b0;
    check("flash_mid_out", out_able, 1'b0);
    nv.pc = 32'h1C00_0150; drive(nv);
    step();
    go_idle();
    check("flash_next_out", out_able, 1'b1);
    check("flash_next_pc", out_pc, 32'h1C00_0150);

    // Flush and acceptance in the same cycle: bundle discarded
    do_flash();
    drive(cv); pre_flash = 1'b1;
    step();
    go_idle();
    check("flash_acc_out", out_able, 1'b0);
    check("flash_acc_up", up_able, 1'b0);
    check("flash_acc_redir", pre_redirect, 1'b0);
    check("flash_acc_state", dbg_state, 1'b0);

    // Reset mid-shadow returns to RUN
    drive(cv);
    step();
    go_idle(); rest = 1'b0;
    step();
    rest = 1'b1;
    nv.pc = 32'h1C00_0160; drive(nv);
    step();
    go_idle();
    check("rst_shd_out", out_able, 1'b1);
    check("rst_shd_pc", out_pc, 32'h1C00_0160);

    // Backpressure: output holds, one update pulse only
    do_flash();
    out_ready = 1'b0;
    rv = vecs[2]; rv.pc = 32'h1C00_0200;
    drive(rv);
    step();
    ups = int'(up_able);
    check("bp_first_out", out_able, 1'b1);
    check("bp_first_up", up_able, 1'b1);
    rv.pc = 32'h1C00_0300; rv.insts = {NOP, RET, NOP, NOP};
    drive(rv);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_ready%0d", c), fetch_ready, 1'b0);
      step();
      ups += int'(up_able);
      check($sformatf("bp_hold_pc%0d", c), out_pc, 32'h1C00_0200);
      check($sformatf("bp_hold_inst%0d", c), out_inst, vecs[2].insts);
      check($sformatf("bp_hold_able%0d", c), out_able, 1'b1);
    end
    go_idle(); out_ready = 1'b1;
    step();
    ups += int'(up_able);
    check("bp_release", out_able, 1'b0);
    check("bp_up_count", ups, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
